// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Holds the FSM encoding, default data-memory base and wait counter width.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int unsigned CNT_W             = 4;
    localparam int unsigned DEFAULT_ADDR_BASE = 1024;

    // Byte address relative to the data-memory base, as a word index; wraps below base.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr,
                                              input logic [31:0] base);
        logic [31:0] offset;
        offset = byte_addr - base;
        return {2'b00, offset[31:2]};
    endfunction

endpackage

// File: rtl/mem_access_ctrl_wait_counter.sv
// Wait-state down-counter: loadable, decrements on request, flags count == 1.
// The count saturates at zero so a stray decrement cannot wrap.
module wait_counter
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle data-memory access controller: freezes the pipeline while a
// load or store runs for WAIT_CYCLES wait states, then releases for one DONE cycle.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned ADDR_BASE   = DEFAULT_ADDR_BASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] st_val,
    input  logic [31:0] mem_rdata,
    output logic        freeze,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] read_data
);

    localparam logic [31:0]      BASE      = 32'(ADDR_BASE);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        cnt_last;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;

    wait_counter #(
        .W(CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (WAIT_LOAD),
        .dec      (state == ACCESS),
        .last     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            read_data <= '0;
        end else begin
            state <= next_state;
            if (accept) begin
                lat_addr <= word_addr(address, BASE);
                lat_data <= st_val;
                lat_we   <= mem_w_en & ~mem_r_en;
            end
            if ((state == ACCESS) && cnt_last && !lat_we) begin
                read_data <= mem_rdata;
            end
        end
    end

    // Requests seen in DONE belong to the access just finished, so only IDLE accepts.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        freeze     = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (mem_r_en || mem_w_en) begin
                    accept     = 1'b1;
                    freeze     = 1'b1;
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                mem_req = 1'b1;
                freeze  = 1'b1;
                if (cnt_last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (rst) begin
            accept  = 1'b0;
            freeze  = 1'b0;
            mem_req = 1'b0;
        end
    end

    assign mem_we    = mem_req & lat_we;
    assign mem_addr  = mem_req ? lat_addr : '0;
    assign mem_wdata = mem_req ? lat_data : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl (WAIT_CYCLES = 3, ADDR_BASE = 1024).
// Each cycle: inputs change 1 time unit after the rising edge, outputs sampled 1 unit later.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] address;
    logic [31:0] st_val;
    logic [31:0] mem_rdata;
    logic        freeze;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] read_data;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(
        .WAIT_CYCLES(3),
        .ADDR_BASE  (1024)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_r_en  (mem_r_en),
        .mem_w_en  (mem_w_en),
        .address   (address),
        .st_val    (st_val),
        .mem_rdata (mem_rdata),
        .freeze    (freeze),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .read_data (read_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b0;
        address = 32'd1032; st_val = 32'h0; mem_rdata = 32'h0000_0042;
        for (int c = 0; c < 2; c++) begin
            tick(); settle();
            checks++;
            if (freeze !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
                mem_addr !== 32'h0 || read_data !== 32'h0) begin
                $display("FAIL reset_hold cyc%0d: freeze=%b req=%b we=%b addr=%h rd=%h, want all 0",
                         c, freeze, mem_req, mem_we, mem_addr, read_data);
                errors++;
            end
        end
        tick(); rst = 1'b0; settle();
        checks++;
        if (freeze !== 1'b1 || mem_req !== 1'b0) begin
            $display("FAIL reset_first_accept: freeze=%b req=%b, want 1 0", freeze, mem_req);
            errors++;
        end
        tick(); settle();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'd2) begin
            $display("FAIL reset_first_access: req=%b addr=%h, want 1 2", mem_req, mem_addr);
            errors++;
        end
        tick(); tick(); tick(); mem_r_en = 1'b0; settle();
        checks++;
        if (freeze !== 1'b0 || read_data !== 32'h0000_0042) begin
            $display("FAIL reset_first_done: freeze=%b rd=%h, want 0 00000042", freeze, read_data);
            errors++;
        end
        tick(); settle();
    endtask

    task automatic test_read();
        mem_r_en = 1'b1; address = 32'd1032; mem_rdata = 32'h1111_1111; settle();
        checks++;
        if (freeze !== 1'b1 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
            $display("FAIL read_c0: freeze=%b req=%b addr=%h, want 1 0 0", freeze, mem_req, mem_addr);
            errors++;
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h1111_1111;
            settle();
            checks++;
            if (freeze !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 ||
                mem_addr !== 32'd2 || mem_wdata !== 32'h0) begin
                $display("FAIL read_c%0d: freeze=%b req=%b we=%b addr=%h wdata=%h, want 1 1 0 2 0",
                         c, freeze, mem_req, mem_we, mem_addr, mem_wdata);
                errors++;
            end
        end
        tick(); mem_rdata = 32'h2222_2222; settle();
        checks++;
        if (freeze !== 1'b0 || mem_req !== 1'b0 || read_data !== 32'hDEAD_BEEF) begin
            $display("FAIL read_done: freeze=%b req=%b rd=%h, want 0 0 deadbeef", freeze, mem_req, read_data);
            errors++;
        end
        mem_r_en = 1'b0;
        tick(); settle();
        checks++;
        if (freeze !== 1'b0 || read_data !== 32'hDEAD_BEEF) begin
            $display("FAIL read_hold: freeze=%b rd=%h, want 0 deadbeef", freeze, read_data);
            errors++;
        end
    endtask

    task automatic test_write();
        mem_w_en = 1'b1; address = 32'd1028; st_val = 32'h1234_5678; mem_rdata = 32'h5555_AAAA;
        settle();
        checks++;
        if (freeze !== 1'b1) begin
            $display("FAIL write_c0: freeze=%b, want 1", freeze);
            errors++;
        end
        for (int c = 1; c <= 3; c++) begin
            tick(); settle();
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'd1 ||
                mem_wdata !== 32'h1234_5678 || freeze !== 1'b1) begin
                $display("FAIL write_c%0d: req=%b we=%b addr=%h wdata=%h freeze=%b, want 1 1 1 12345678 1",
                         c, mem_req, mem_we, mem_addr, mem_wdata, freeze);
                errors++;
            end
        end
        tick(); mem_w_en = 1'b0; settle();
        checks++;
        if (freeze !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== 32'h0 ||
            read_data !== 32'hDEAD_BEEF) begin
            $display("FAIL write_done: freeze=%b we=%b wdata=%h rd=%h, want 0 0 0 deadbeef",
                     freeze, mem_we, mem_wdata, read_data);
            errors++;
        end
        tick(); settle();
    endtask

    task automatic test_back_to_back();
        logic exp_req;
        logic exp_frz;
        int   req_cycles = 0;
        mem_r_en = 1'b1; address = 32'd1040; mem_rdata = 32'hCAFE_F00D; settle();
        for (int c = 1; c <= 10; c++) begin
            tick(); settle();
            exp_req = (c >= 1 && c <= 3) || (c >= 6 && c <= 8);
            exp_frz = (c >= 1 && c <= 3) || (c >= 5 && c <= 8);
            if (mem_req === 1'b1) req_cycles++;
            checks++;
            if (mem_req !== exp_req || freeze !== exp_frz) begin
                $display("FAIL b2b_c%0d: req=%b freeze=%b, want %b %b", c, mem_req, freeze, exp_req, exp_frz);
                errors++;
            end
            if (c == 6) mem_r_en = 1'b0;
        end
        checks++;
        if (req_cycles != 6 || read_data !== 32'hCAFE_F00D) begin
            $display("FAIL b2b_total: req_cycles=%0d rd=%h, want 6 cafef00d", req_cycles, read_data);
            errors++;
        end
    endtask

    task automatic test_both_enables();
        mem_r_en = 1'b1; mem_w_en = 1'b1; address = 32'd1036; st_val = 32'h1111_2222;
        mem_rdata = 32'h0BAD_F00D; settle();
        for (int c = 1; c <= 3; c++) begin
            tick(); settle();
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd3) begin
                $display("FAIL both_c%0d: req=%b we=%b addr=%h, want 1 0 3", c, mem_req, mem_we, mem_addr);
                errors++;
            end
        end
        tick(); mem_r_en = 1'b0; mem_w_en = 1'b0; settle();
        checks++;
        if (freeze !== 1'b0 || read_data !== 32'h0BAD_F00D) begin
            $display("FAIL both_done: freeze=%b rd=%h, want 0 0badf00d", freeze, read_data);
            errors++;
        end
        tick(); settle();
    endtask

    task automatic test_reset_mid_access();
        int frozen = 0;
        mem_r_en = 1'b1; address = 32'd1032; mem_rdata = 32'h7777_7777; settle();
        tick();
        tick(); rst = 1'b1; mem_r_en = 1'b0;
        tick(); rst = 1'b0; settle();
        checks++;
        if (freeze !== 1'b0 || mem_req !== 1'b0 || read_data !== 32'h0) begin
            $display("FAIL rst_mid_c3: freeze=%b req=%b rd=%h, want 0 0 0", freeze, mem_req, read_data);
            errors++;
        end
        for (int c = 4; c <= 6; c++) begin
            tick(); settle();
            checks++;
            if (mem_req !== 1'b0 || freeze !== 1'b0) begin
                $display("FAIL rst_no_retry_c%0d: req=%b freeze=%b, want 0 0", c, mem_req, freeze);
                errors++;
            end
        end
        // New request below the base: word address wraps.
        mem_r_en = 1'b1; address = 32'd1020; mem_rdata = 32'h3C3C_3C3C; settle();
        if (freeze === 1'b1) frozen++;
        for (int c = 1; c <= 3; c++) begin
            tick(); settle();
            if (freeze === 1'b1) frozen++;
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h3FFF_FFFF) begin
                $display("FAIL wrap_c%0d: req=%b addr=%h, want 1 3fffffff", c, mem_req, mem_addr);
                errors++;
            end
        end
        tick(); mem_r_en = 1'b0; settle();
        if (freeze === 1'b1) frozen++;
        checks++;
        if (frozen != 4 || read_data !== 32'h3C3C_3C3C) begin
            $display("FAIL wrap_done: frozen=%0d rd=%h, want 4 3c3c3c3c", frozen, read_data);
            errors++;
        end
        tick(); settle();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_both_enables();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 3; memory access wait states, legal range 1..15.
REQ-002 SHALL have parameter ADDR_BASE, default 1024; data-memory base subtracted from the byte address.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port mem_r_en, input, 1: load request from the EXE/MEM pipeline register.
REQ-006 SHALL have port mem_w_en, input, 1: store request from the EXE/MEM pipeline register.
REQ-007 SHALL have port address, input, 32: byte address (ALU result).
REQ-008 SHALL have port st_val, input, 32: store data (Rm value).
REQ-009 SHALL have port mem_rdata, input, 32: read data returned by memory.
REQ-010 SHALL have port freeze, output, 1: stall for all pipeline registers and the PC.
REQ-011 SHALL have port mem_req, output, 1: memory access strobe.
REQ-012 SHALL have port mem_we, output, 1: 1 = write, 0 = read.
REQ-013 SHALL have port mem_addr, output, 32: word address.
REQ-014 SHALL have port mem_wdata, output, 32: write data.
REQ-015 SHALL have port read_data, output, 32: captured load result to the WB stage.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-017 IDLE with mem_r_en or mem_w_en = 1: freeze SHALL be 1 combinationally in that cycle, address/st_val/operation SHALL be latched, counter loaded with WAIT_CYCLES, and the next state SHALL be ACCESS.
REQ-018 IDLE with no request: freeze, mem_req = 0; FSM stays in IDLE.
REQ-019 mem_r_en and mem_w_en both 1: SHALL be treated as a read; the write is dropped.
REQ-020 ACCESS: mem_req = 1, freeze = 1, mem_we/mem_addr/mem_wdata SHALL be driven from the latched values, stable for all ACCESS cycles; counter decrements every cycle.
REQ-021 ACCESS with counter = 1: next state SHALL be DONE; for reads, read_data SHALL capture mem_rdata on that edge.
REQ-022 DONE: freeze = 0, mem_req = 0; lasts exactly 1 cycle, then IDLE; request inputs SHALL be ignored in DONE, since they still show the completed access.
REQ-023 Timing: request first seen in cycle 0 gives freeze high for cycles 0..WAIT_CYCLES and DONE in cycle WAIT_CYCLES+1.
REQ-024 Back-to-back accesses: a new request SHALL be accepted in IDLE the cycle after DONE.
REQ-025 mem_addr SHALL be ((address - ADDR_BASE) mod 2^32) >> 2; the low 2 bits are ignored; addresses below ADDR_BASE wrap with no error.
REQ-026 read_data SHALL hold its value until the next read completes; writes SHALL NOT change read_data.
REQ-027 mem_we, mem_addr and mem_wdata SHALL be 0 whenever mem_req = 0.

Reset
REQ-028 When rst = 1 at a clock edge, the state SHALL become IDLE and the counter, latched address/data, and read_data SHALL become 0.
REQ-029 While in reset, freeze, mem_req and mem_we SHALL be 0; this holds even when rst is asserted mid-ACCESS, and the aborted access is not retried.
REQ-030 The first request SHALL be accepted in the cycle after rst deasserts.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE, ACCESS, DONE), the default ADDR_BASE and the counter width (4).
REQ-032 The wait-state down-counter SHALL be a sub-module wait_counter, with load, decrement and a last flag for count = 1.
REQ-033 The design SHALL contain no other submodules and SHALL be synthesizable with one clock domain.

Verification (WAIT_CYCLES = 3, ADDR_BASE = 1024)
REQ-034 Read at address 1032 in cycle 0, mem_rdata = 0xDEADBEEF: freeze = 1 for cycles 0-3, mem_addr = 2 with mem_we = 0 in cycles 1-3, DONE in cycle 4, read_data = 0xDEADBEEF from cycle 4.
REQ-035 Write at address 1028 with st_val 0x12345678: mem_req = 1, mem_we = 1, mem_addr = 1, mem_wdata = 0x12345678 in cycles 1-3; read_data unchanged.
REQ-036 Inputs held through DONE, then a second read in the next cycle: exactly two accesses, no duplicate; second access starts in cycle 5.
REQ-037 Both enables = 1: a read occurs with mem_we = 0 throughout.
REQ-038 rst = 1 in cycle 2 of an access: from cycle 3, state = IDLE and freeze, mem_req and read_data are all 0; a new request after reset completes normally.
REQ-039 Address 1020 (below base): mem_addr = 0x3FFFFFFF; the access completes in 4 frozen cycles.
